// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch display stage: status codes,
// 7-segment encoding and conversion FSM states.
package stopwatch_pkg;

  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_RUNNING = 2'b01;
  localparam logic [1:0] ST_PAUSED  = 2'b10;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam int unsigned SHIFT_CYCLES = 8;

  typedef enum logic [1:0] {
    CV_CAPTURE = 2'd0,
    CV_SHIFT   = 2'd1,
    CV_COMMIT  = 2'd2
  } conv_state_t;

  // Active-low common-anode segment pattern, bit0=a .. bit6=g
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter, one shift per cycle.
// NDIG only needs to cover the largest value actually fed in.
module bin2bcd_seq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NDIG  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*NDIG-1:0]     bcd
);

  localparam int unsigned BCD_W = 4 * NDIG;
  localparam int unsigned SR_W  = BCD_W + WIDTH;
  localparam int unsigned CNT_W = $clog2(WIDTH);

  logic [SR_W-1:0]  sr;
  logic [SR_W-1:0]  sr_nxt;
  logic [CNT_W-1:0] cnt;

  // Add 3 to every BCD digit >= 5, then shift the whole register left
  always_comb begin
    sr_nxt = sr;
    for (int i = 0; i < int'(NDIG); i++) begin
      if (sr_nxt[WIDTH + 4*i +: 4] >= 4'd5)
        sr_nxt[WIDTH + 4*i +: 4] = sr_nxt[WIDTH + 4*i +: 4] + 4'd3;
    end
    sr_nxt = sr_nxt << 1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr   <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        sr   <= {BCD_W'(0), bin};
        cnt  <= '0;
        busy <= 1'b1;
      end else if (busy) begin
        sr  <= sr_nxt;
        cnt <= cnt + CNT_W'(1);
        if (cnt == CNT_W'(WIDTH - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign bcd = sr[SR_W-1 -: BCD_W];

endmodule

// File: rtl/stopwatch_display.sv
// MM.SS multiplexed 7-segment driver: snapshot BCD conversion loop,
// digit scan, blink timebase and status-dependent output registers.
module stopwatch_display
  import stopwatch_pkg::*;
#(
  parameter int unsigned DIGIT_PERIOD = 50000,
  parameter int unsigned BLINK_PERIOD = 25000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  minutes,
  input  logic [5:0]  seconds,
  input  logic [1:0]  status,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic [3:0]  an_n,
  output logic [15:0] digits_bcd,
  output logic        ovf
);

  localparam int unsigned SCAN_W  = $clog2(DIGIT_PERIOD);
  localparam int unsigned BLINK_W = $clog2(BLINK_PERIOD);
  localparam int unsigned SH_W    = $clog2(SHIFT_CYCLES);

  conv_state_t       state;
  logic [SH_W-1:0]   shift_cnt;
  logic              ovf_pending;
  logic              start_c;
  logic [7:0]        min_in_c;
  logic              min_busy, sec_busy, min_done, sec_done;
  logic [7:0]        min_bcd, sec_bcd;

  logic [SCAN_W-1:0]  scan_cnt;
  logic [1:0]         digit_idx;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_phase;
  logic [3:0]         nibble_c;
  logic               dp_c;

  // Both converters load in the same CAPTURE cycle, so the pair is atomic
  assign start_c  = (state == CV_CAPTURE) && !min_busy && !sec_busy;
  assign min_in_c = (minutes > 8'd99) ? 8'd99 : minutes;

  bin2bcd_seq #(.WIDTH(8), .NDIG(2)) u_min_conv (
    .clk   (clk),
    .rst   (rst),
    .start (start_c),
    .bin   (min_in_c),
    .busy  (min_busy),
    .done  (min_done),
    .bcd   (min_bcd)
  );

  bin2bcd_seq #(.WIDTH(8), .NDIG(2)) u_sec_conv (
    .clk   (clk),
    .rst   (rst),
    .start (start_c),
    .bin   ({2'b00, seconds}),
    .busy  (sec_busy),
    .done  (sec_done),
    .bcd   (sec_bcd)
  );

  // Conversion loop: CAPTURE -> 8 x SHIFT -> COMMIT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= CV_CAPTURE;
      shift_cnt   <= '0;
      ovf_pending <= 1'b0;
      digits_bcd  <= '0;
      ovf         <= 1'b0;
    end else begin
      case (state)
        CV_CAPTURE: begin
          if (start_c) begin
            ovf_pending <= (minutes > 8'd99);
            shift_cnt   <= '0;
            state       <= CV_SHIFT;
          end
        end
        CV_SHIFT: begin
          shift_cnt <= shift_cnt + SH_W'(1);
          if (shift_cnt == SH_W'(SHIFT_CYCLES - 1))
            state <= CV_COMMIT;
        end
        CV_COMMIT: begin
          if (min_done && sec_done) begin
            digits_bcd <= {min_bcd, sec_bcd};
            ovf        <= ovf_pending;
          end
          state <= CV_CAPTURE;
        end
        default: state <= CV_CAPTURE;
      endcase
    end
  end

  // Scan and blink timebases run free of status
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt    <= '0;
      digit_idx   <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      if (scan_cnt == SCAN_W'(DIGIT_PERIOD - 1)) begin
        scan_cnt  <= '0;
        digit_idx <= digit_idx + 2'd1;
      end else begin
        scan_cnt <= scan_cnt + SCAN_W'(1);
      end
      if (blink_cnt == BLINK_W'(BLINK_PERIOD - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BLINK_W'(1);
      end
    end
  end

  assign nibble_c = digits_bcd[{digit_idx, 2'b00} +: 4];

  // Colon sits on the minutes-ones digit
  always_comb begin
    dp_c = 1'b1;
    if (digit_idx == 2'd2) begin
      case (status)
        ST_IDLE:    dp_c = 1'b1;
        ST_RUNNING: dp_c = ~blink_phase;
        ST_PAUSED:  dp_c = 1'b0;
        default:    dp_c = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_n <= SEG_BLANK;
      an_n  <= 4'hF;
      dp_n  <= 1'b1;
    end else if (status == ST_PAUSED && blink_phase) begin
      seg_n <= SEG_BLANK;
      an_n  <= 4'hF;
      dp_n  <= 1'b1;
    end else begin
      seg_n <= seg_decode(nibble_c);
      an_n  <= ~(4'b0001 << digit_idx);
      dp_n  <= dp_c;
    end
  end

endmodule

// File: tb/tb_stopwatch_display.sv
// Self-checking bench for stopwatch_display with a cycle-indexed reference model.
module tb_stopwatch_display;

  localparam int unsigned DP = 4;
  localparam int unsigned BP = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  minutes = '0;
  logic [5:0]  seconds = '0;
  logic [1:0]  status = '0;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  an_n;
  logic [15:0] digits_bcd;
  logic        ovf;

  stopwatch_display #(.DIGIT_PERIOD(DP), .BLINK_PERIOD(BP)) dut (
    .clk        (clk),
    .rst        (rst),
    .minutes    (minutes),
    .seconds    (seconds),
    .status     (status),
    .seg_n      (seg_n),
    .dp_n       (dp_n),
    .an_n       (an_n),
    .digits_bcd (digits_bcd),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  // Reference model state: k = clock edges since reset release
  int          k;
  int          snap_min, snap_sec;
  logic        snap_ovf;
  logic [15:0] m_digits;
  logic        m_ovf;

  typedef struct {
    int          mins;
    int          secs;
    int          st;
    logic [15:0] exp_bcd;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  task automatic model_reset();
    k        = 0;
    snap_min = 0;
    snap_sec = 0;
    snap_ovf = 1'b0;
    m_digits = '0;
    m_ovf    = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_seg_n"},  32'(seg_n),      32'h7F);
    check({tag, "_an_n"},   32'(an_n),       32'hF);
    check({tag, "_dp_n"},   32'(dp_n),       32'h1);
    check({tag, "_digits"}, 32'(digits_bcd), 32'h0);
    check({tag, "_ovf"},    32'(ovf),        32'h0);
  endtask

  // One clock edge: predict outputs from pre-edge state, then verify
  task automatic tick();
    int idx, ph, nib;
    logic [6:0] e_seg;
    logic [3:0] e_an;
    logic       e_dp;
    @(posedge clk);
    k++;
    idx = ((k - 1) / DP) % 4;
    ph  = ((k - 1) / BP) % 2;
    if (status == 2'b10 && ph == 1) begin
      e_seg = 7'h7F;
      e_an  = 4'hF;
      e_dp  = 1'b1;
    end else begin
      nib   = int'((m_digits >> (4 * idx)) & 16'hF);
      e_seg = (nib < 10) ? seg_tab[nib] : 7'h7F;
      e_an  = 4'(~(1 << idx));
      e_dp  = 1'b1;
      if (idx == 2) begin
        if (status == 2'b01)      e_dp = (ph == 0);
        else if (status == 2'b10) e_dp = 1'b0;
      end
    end
    if ((k - 1) % 10 == 0) begin
      snap_ovf = (minutes > 8'd99);
      snap_min = snap_ovf ? 99 : int'(minutes);
      snap_sec = int'(seconds);
    end
    if (k % 10 == 0) begin
      m_digits = {to_bcd(snap_min), to_bcd(snap_sec)};
      m_ovf    = snap_ovf;
    end
    #1;
    check("seg_n",  32'(seg_n),      32'(e_seg));
    check("an_n",   32'(an_n),       32'(e_an));
    check("dp_n",   32'(dp_n),       32'(e_dp));
    check("digits", 32'(digits_bcd), 32'(m_digits));
    check("ovf",    32'(ovf),        32'(m_ovf));
  endtask

  task automatic set_in(input int m, input int s, input int st);
    minutes = 8'(m);
    seconds = 6'(s);
    status  = 2'(st);
  endtask

  // Assert reset between edges, confirm outputs clear without a clock, then release
  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1 check_reset_vals(tag);
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_reset_vals({tag, "_held"});
    #2 rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int blanks;
    logic [15:0] d;

    vecs[0] = '{12,  34, 1, 16'h1234, 1'b0};
    vecs[1] = '{150, 34, 1, 16'h9934, 1'b1};
    vecs[2] = '{5,   34, 0, 16'h0534, 1'b0};
    vecs[3] = '{7,   45, 2, 16'h0745, 1'b0};
    vecs[4] = '{99,  59, 1, 16'h9959, 1'b0};
    vecs[5] = '{100, 63, 2, 16'h9963, 1'b1};
    vecs[6] = '{0,   60, 0, 16'h0060, 1'b0};
    vecs[7] = '{255, 0,  3, 16'h9900, 1'b1};

    model_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_reset_vals("rst_hold");
    #2 rst = 1'b0;
    tick();
    check("first_an",  32'(an_n),  32'hE);
    check("first_seg", 32'(seg_n), 32'h40);

    // Table-driven vectors: value must be committed within 20 cycles
    foreach (vecs[i]) begin
      set_in(vecs[i].mins, vecs[i].secs, vecs[i].st);
      repeat (20) tick();
      check("vec_bcd", 32'(digits_bcd), 32'(vecs[i].exp_bcd));
      check("vec_ovf", 32'(ovf),        32'(vecs[i].exp_ovf));
    end

    // Paused: half of every 32 cycles is fully blanked
    set_in(7, 45, 2);
    repeat (20) tick();
    blanks = 0;
    for (int j = 0; j < 32; j++) begin
      tick();
      if (an_n == 4'hF && seg_n == 7'h7F) blanks++;
    end
    check("pause_blank_count", 32'(blanks), 32'd16);

    // Atomic snapshot: 03:59 -> 04:00 at every phase of the conversion loop
    for (int off = 0; off < 10; off++) begin
      set_in(3, 59, 1);
      repeat (20) tick();
      check("step_pre", 32'(digits_bcd), 32'h0359);
      repeat (off) tick();
      set_in(4, 0, 1);
      for (int j = 0; j < 20; j++) begin
        tick();
        d = digits_bcd;
        check("step_nomix", 32'((d == 16'h0359) || (d == 16'h0400)), 32'd1);
      end
      check("step_post", 32'(digits_bcd), 32'h0400);
    end

    // Reset in the middle of a SHIFT phase
    for (int j = 0; j < 10 && (k % 10) != 4; j++) tick();
    async_reset("rst_mid_shift");
    set_in(21, 9, 1);
    repeat (20) tick();
    check("resume_bcd", 32'(digits_bcd), 32'h2109);

    // Randomised run against the model
    for (int i = 0; i < 40; i++) begin
      set_in(int'($urandom_range(0, 255)), int'($urandom_range(0, 63)),
             int'($urandom_range(0, 3)));
      repeat ($urandom_range(1, 25)) tick();
      if (i == 20) begin
        repeat ($urandom_range(0, 7)) tick();
        async_reset("rst_mid_scan");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
